// File: rtl/countdown_pkg.sv
// countdown_pkg: shared constants, count type and parameter check
// for the countdown timer bank and its prescaler.
package countdown_pkg;

  localparam int W_DEF         = 7;
  localparam int N_CH_DEF      = 2;
  localparam int CYCLE_DEF     = 100_000_000;
  localparam int FORCE_VAL_DEF = 21;
  localparam int SIM_CYCLE     = 4;

  typedef logic [W_DEF-1:0] count_t;

  // True when the prescaler period is usable and the
  // force value fits in a w-bit channel.
  function automatic bit cfg_ok(int cycle, int force_val, int w);
    longint lim;
    lim = longint'(1) << w;
    return (cycle >= 1) && (force_val >= 0) &&
           (longint'(force_val) < lim);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running 0..CYCLE-1 counter, registered 1-cycle tick.
// Ports: clk, rst (sync, active-high), tick (period CYCLE clk cycles).
module tick_prescaler
  import countdown_pkg::*;
#(
  parameter int CYCLE = SIM_CYCLE
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  // One bit minimum so CYCLE=1 still elaborates; the
  // counter then sits at 0 and tick fires every cycle.
  localparam int CW = (CYCLE > 1) ? $clog2(CYCLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLE - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/countdown_timer_bank.sv
// countdown_timer_bank: N_CH saturating down-counters on one shared tick.
// Ports: clk, rst (sync, active-high); per channel load/load_val/pause/
// force_en in; count/expired/done_pulse out; shared tick out.
// Build option: COUNTDOWN_AUTORELOAD_EN reloads the last loaded value
// on each tick-driven 1->0 step.
module countdown_timer_bank
  import countdown_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int N_CH      = N_CH_DEF,
  parameter int CYCLE     = CYCLE_DEF,
  parameter int FORCE_VAL = FORCE_VAL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   load,
  input  logic [N_CH*W-1:0] load_val,
  input  logic [N_CH-1:0]   pause,
  input  logic [N_CH-1:0]   force_en,
  output logic [N_CH*W-1:0] count,
  output logic [N_CH-1:0]   expired,
  output logic [N_CH-1:0]   done_pulse,
  output logic              tick
);

  localparam logic [W-1:0] FV  = W'(FORCE_VAL);
  localparam logic [W-1:0] ONE = W'(1);

  if (!cfg_ok(CYCLE, FORCE_VAL, W)) begin : g_bad_cfg
    $error("countdown_timer_bank: CYCLE<1 or FORCE_VAL too wide");
  end

  logic w_tick;

  tick_prescaler #(
    .CYCLE(CYCLE)
  ) u_presc (
    .clk (clk),
    .rst (rst),
    .tick(w_tick)
  );

  assign tick = w_tick;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [W-1:0] r_cnt;
    logic         r_exp;
    logic         r_done;
    logic [W-1:0] w_nxt;
    logic [W-1:0] w_zero_val;
    logic         w_done;

`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [W-1:0] r_rld;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_rld <= '0;
      end else if (load[i]) begin
        r_rld <= load_val[i*W +: W];
      end
    end

    assign w_zero_val = r_rld;
`else
    assign w_zero_val = '0;
`endif

    // Priority: load, force, tick-driven decrement, hold.
    always_comb begin
      w_nxt  = r_cnt;
      w_done = 1'b0;
      if (load[i]) begin
        w_nxt = load_val[i*W +: W];
      end else if (force_en[i]) begin
        w_nxt = FV;
      end else if (w_tick && !pause[i] && (r_cnt != '0)) begin
        w_done = (r_cnt == ONE);
        w_nxt  = w_done ? w_zero_val : r_cnt - ONE;
      end
    end

    // expired tracks the value being written, so it
    // lines up with count in the same cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt  <= '0;
        r_exp  <= 1'b1;
        r_done <= 1'b0;
      end else begin
        r_cnt  <= w_nxt;
        r_exp  <= (w_nxt == '0);
        r_done <= w_done;
      end
    end

    assign count[i*W +: W] = r_cnt;
    assign expired[i]      = r_exp;
    assign done_pulse[i]   = r_done;
  end

endmodule

// File: doc/countdown_timer_bank.md
Name: countdown_timer_bank

Overview:
- Parametrised successor to the single-channel countdown clock.
- N_CH independent down-counters of width W, all driven by one shared prescaler tick.
- Each channel has load, pause and force-display controls, plus expiry level and done-pulse outputs.
- Sits between the control FSM (which loads and pauses channels) and the 7-segment display/alarm logic.

Parameters:
- W, 7, counter width per channel (max count 2^W-1).
- N_CH, 2, number of independent channels.
- CYCLE, 100_000_000, clk cycles per tick; must be >= 1. Simulation uses 4.
- FORCE_VAL, 21, value loaded when a channel's force bit is high.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- load  in  N_CH  per-channel load strobe.
- load_val  in  N_CH*W  per-channel load value; channel i occupies bits [i*W +: W].
- pause  in  N_CH  per-channel hold (ignore ticks).
- force_en  in  N_CH  per-channel override to FORCE_VAL.
- count  out  N_CH*W  registered current value per channel.
- expired  out  N_CH  registered; 1 when the channel count is 0.
- done_pulse  out  N_CH  1-cycle pulse on a tick-driven 1->0 transition.
- tick  out  1  1-cycle prescaler strobe, shared by all channels.

Behaviour:
- Reset (rst=1 at a clk edge): prescaler=0, tick=0, all count=0, expired=all 1, done_pulse=0. Reset takes priority over every input.
- Prescaler: free-running 0..CYCLE-1, cleared only by rst.
  - tick is registered; it is 1 in the cycle after the prescaler reaches CYCLE-1, so its period is exactly CYCLE clk cycles.
  - CYCLE=1: tick is high every cycle after reset.
- Per-channel update each clk edge, highest priority first:
  1. load: count<=load_val[i]; done_pulse<=0.
  2. force_en: count<=FORCE_VAL; done_pulse<=0.
  3. tick & ~pause & count!=0: count<=count-1; done_pulse<=1 iff count==1.
  4. Otherwise: count holds; done_pulse<=0.
- Saturation: count never wraps. A tick at 0 leaves 0 and produces no pulse.
- expired is registered alongside count: it equals (next count == 0), so it is never a cycle behind count.
- Load latency: 1 cycle. A load of 0 gives count=0 and expired=1 with no done_pulse.
- Pause does not affect the prescaler, so unpausing resumes on the next shared tick. The phase is not restarted.
- Simultaneous events:
  - load beats force.
  - load beats a tick in the same cycle; the tick is lost for that channel.
  - Channels are fully independent of each other.
- FORCE_VAL is truncated to W bits; elaboration asserts FORCE_VAL < 2^W.
- Reset mid-count: the next cycle shows count=0 and expired=1. No done_pulse is generated by reset.

Optional Feature:
- Macro: COUNTDOWN_AUTORELOAD_EN.
- Defined:
  - Each channel keeps a W-bit reload register, captured on load (reset value 0).
  - A tick-driven 1->0 transition writes the reload value into count instead of 0, and done_pulse still fires.
  - expired stays 0 through the reload unless the reload value is 0.
  - force_en does not change the reload register.
- Undefined: no reload registers exist; the count holds at 0 after expiry.

Decomposition:
- Package countdown_pkg holds:
  - constants: default W, N_CH, CYCLE, FORCE_VAL, and SIM_CYCLE=4;
  - a typedef for a W-bit count;
  - a function that checks CYCLE>=1 and FORCE_VAL<2^W.
- Sub-module tick_prescaler (parameter CYCLE; ports clk, rst, tick) holds the shared prescaler.
- The per-channel logic is a generate loop in the top module, not a separate sub-module.

Test Plan (W=7, N_CH=2, CYCLE=4):
- Reset: hold rst for 2 cycles -> count=0/0, expired=11, done_pulse=00, tick=0.
- Basic countdown: load ch0=3 -> count0=3 one cycle later, then 2, 1, 0 on successive ticks (4 cycles apart). done_pulse0 is high for exactly 1 cycle with the 1->0 step, and expired0 rises in the same cycle.
- Pause independence: pause ch1 after loading 5 while ch0 counts from 5 -> ch1 holds 5 while ch0 reaches 0; unpause -> ch1 decrements on the very next tick.
- Priority: in one cycle assert load ch0=9, force_en0 and a tick -> count0=9. Next, force_en0 alone -> count0=21 with no done_pulse.
- Saturation and zero load: load 0 -> expired=1 and no pulse; run 3 ticks -> count stays 0 and no pulse. Assert rst mid-count at 2 -> count=0 next cycle with no pulse.
- With COUNTDOWN_AUTORELOAD_EN: load 2 -> sequence 2, 1, 2, 1, ... with done_pulse on each 1->2 step and expired never 1.
